rle_word_packer: RTL and testbench

- Upstream neighbour of the IO loader. Serialises typed header and matrix fields (n, m, mode, H, tolerance, fixed point, count, matrix entries) MSB-first into one bitstream.
- Run-length encodes the bitstream into 32-bit words of eight {bit, len[2:0]} nibbles and hands each word to the loader over the interrupt/load_process/done_cpu handshake.
- Runs continue across field boundaries, because the loader decodes one continuous bitstream.

---
 rtl/rle_word_packer.sv | 223 ++++++++++++++++++++++
 tb/tb_rle_word_packer.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rle_word_packer.sv
// Serialises typed fields MSB-first, run-length encodes the bitstream into 32-bit words of
// eight {bit,len[2:0]} nibbles and hands each word to the loader. Optional RLE_PACK_STATS_EN adds counters.
module rle_word_packer #(
   parameter int MAX_RUN = 7,
   parameter int FIELD_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               field_valid,
   output logic               field_ready,
   input  logic [FIELD_W-1:0] field_data,
   input  logic [4:0]         field_width,
   input  logic               flush,
   input  logic               load_active,
   output logic [31:0]        data,
   output logic               interrupt,
   output logic               load_process,
   input  logic               done_cpu,
   output logic               busy,
   output logic               error
`ifdef RLE_PACK_STATS_EN
   ,
   output logic [15:0]        words_sent,
   output logic [15:0]        bits_packed
`endif
);

   localparam logic [4:0] FW_C      = 5'(FIELD_W);
   localparam logic [2:0] MAX_RUN_C = 3'(MAX_RUN);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SHIFT    = 2'd1,
      EMIT     = 2'd2,
      WAIT_ACK = 2'd3
   } state_t;

   state_t             state_r, state_s;
   logic [FIELD_W-1:0] sh_r, sh_s;
   logic [4:0]         cnt_r, cnt_s;
   logic               run_open_r, run_open_s;
   logic               cur_bit_r, cur_bit_s;
   logic [2:0]         len_r, len_s;
   logic [31:0]        buf_r, buf_s;
   logic [3:0]         nib_r, nib_s;
   logic               flush_pend_r, flush_pend_s;
   logic [31:0]        data_r, data_s;
   logic               done_prev_r;
   logic               interrupt_r, field_ready_r, busy_r, error_r, load_process_r;
   logic               field_ready_s, busy_s;
   logic               accept_s, bad_w_s, load_ok_s, ack_edge_s, bit_s;

   // Slot 7 is decoded first, so closed nibble number idx lands in slot 7-idx.
   function automatic logic [31:0] put_nibble(input logic [31:0] word, input logic [2:0] idx,
                                              input logic [3:0] nib);
      logic [31:0] res;
      res = word;
      res[{3'd7 - idx, 2'b00} +: 4] = nib;
      return res;
   endfunction

   // Next-state, run builder and flush servicing
   always_comb begin
      state_s      = state_r;
      sh_s         = sh_r;
      cnt_s        = cnt_r;
      run_open_s   = run_open_r;
      cur_bit_s    = cur_bit_r;
      len_s        = len_r;
      buf_s        = buf_r;
      nib_s        = nib_r;
      flush_pend_s = flush_pend_r;
      data_s       = data_r;
      bit_s        = sh_r[FIELD_W-1];
      accept_s     = field_valid && field_ready_r;
      bad_w_s      = accept_s && (field_width > FW_C);
      load_ok_s    = accept_s && (field_width != 5'd0) && (field_width <= FW_C);
      ack_edge_s   = done_cpu && !done_prev_r;

      case (state_r)
         IDLE: begin
            if (load_ok_s) begin
               sh_s    = field_data << (FW_C - field_width);
               cnt_s   = field_width;
               state_s = SHIFT;
            end else if (flush_pend_r) begin
               flush_pend_s = 1'b0;
               if (run_open_r) begin
                  // Unused slots stay 4'h0 from the buffer clear, which is the padding.
                  buf_s      = put_nibble(buf_r, nib_r[2:0], {cur_bit_r, len_r});
                  nib_s      = nib_r + 4'd1;
                  run_open_s = 1'b0;
                  len_s      = 3'd0;
                  state_s    = EMIT;
               end else if (nib_r != 4'd0) begin
                  state_s = EMIT;
               end else begin
                  state_s = IDLE;
               end
            end else begin
               state_s = IDLE;
            end
         end
         SHIFT: begin
            if (load_ok_s) begin
               sh_s  = field_data << (FW_C - field_width);
               cnt_s = field_width;
            end else begin
               sh_s  = sh_r << 1;
               cnt_s = cnt_r - 5'd1;
            end
            if (!run_open_r) begin
               run_open_s = 1'b1;
               cur_bit_s  = bit_s;
               len_s      = 3'd1;
            end else if ((bit_s == cur_bit_r) && (len_r < MAX_RUN_C)) begin
               len_s = len_r + 3'd1;
            end else begin
               buf_s     = put_nibble(buf_r, nib_r[2:0], {cur_bit_r, len_r});
               nib_s     = nib_r + 4'd1;
               cur_bit_s = bit_s;
               len_s     = 3'd1;
            end
            if (nib_s == 4'd8) begin
               state_s = EMIT;
            end else if (cnt_s == 5'd0) begin
               state_s = IDLE;
            end else begin
               state_s = SHIFT;
            end
         end
         EMIT: begin
            data_s  = buf_r;
            state_s = WAIT_ACK;
         end
         WAIT_ACK: begin
            if (ack_edge_s) begin
               buf_s   = 32'h0000_0000;
               nib_s   = 4'd0;
               state_s = (cnt_r != 5'd0) ? SHIFT : IDLE;
            end else begin
               state_s = WAIT_ACK;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase

      flush_pend_s  = flush_pend_s | flush;
      field_ready_s = (state_s == IDLE) || ((state_s == SHIFT) && (cnt_s == 5'd1));
      busy_s        = (cnt_s != 5'd0) || run_open_s || (nib_s != 4'd0) || flush_pend_s;
   end

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r        <= IDLE;
         sh_r           <= '0;
         cnt_r          <= 5'd0;
         run_open_r     <= 1'b0;
         cur_bit_r      <= 1'b0;
         len_r          <= 3'd0;
         buf_r          <= 32'h0000_0000;
         nib_r          <= 4'd0;
         flush_pend_r   <= 1'b0;
         data_r         <= 32'h0000_0000;
         done_prev_r    <= 1'b0;
         interrupt_r    <= 1'b0;
         field_ready_r  <= 1'b0;
         busy_r         <= 1'b0;
         error_r        <= 1'b0;
         load_process_r <= 1'b0;
      end else begin
         state_r        <= state_s;
         sh_r           <= sh_s;
         cnt_r          <= cnt_s;
         run_open_r     <= run_open_s;
         cur_bit_r      <= cur_bit_s;
         len_r          <= len_s;
         buf_r          <= buf_s;
         nib_r          <= nib_s;
         flush_pend_r   <= flush_pend_s;
         data_r         <= data_s;
         done_prev_r    <= done_cpu;
         interrupt_r    <= (state_s == WAIT_ACK);
         field_ready_r  <= field_ready_s;
         busy_r         <= busy_s;
         error_r        <= bad_w_s;
         load_process_r <= load_active;
      end
   end

   assign field_ready  = field_ready_r;
   assign data         = data_r;
   assign interrupt    = interrupt_r;
   assign load_process = load_process_r;
   assign busy         = busy_r;
   assign error        = error_r;

`ifdef RLE_PACK_STATS_EN
   logic [15:0] words_sent_r, bits_packed_r;

   // Activity counters; each SHIFT cycle consumes exactly one bit
   always_ff @(posedge clk) begin
      if (rst) begin
         words_sent_r  <= 16'd0;
         bits_packed_r <= 16'd0;
      end else begin
         if ((state_r == WAIT_ACK) && ack_edge_s) begin
            words_sent_r <= words_sent_r + 16'd1;
         end
         if (state_r == SHIFT) begin
            bits_packed_r <= bits_packed_r + 16'd1;
         end
      end
   end

   assign words_sent  = words_sent_r;
   assign bits_packed = bits_packed_r;
`endif

endmodule

// File: tb/tb_rle_word_packer.sv
// Self-checking bench for rle_word_packer: spec vectors, handshake corner cases and
// randomized field streams against a queue-based run-length model.
module tb_rle_word_packer;
   localparam int MAX_RUN = 7;

   logic        clk = 1'b0, rst = 1'b1;
   logic        field_valid = 1'b0, flush = 1'b0, load_active = 1'b0;
   logic [15:0] field_data = 16'h0000;
   logic [4:0]  field_width = 5'd0;
   logic        field_ready, interrupt, load_process, busy, error;
   logic [31:0] data;
   logic        done_cpu, done_auto = 1'b0, done_man = 1'b0, auto_ack = 1'b1;
`ifdef RLE_PACK_STATS_EN
   logic [15:0] words_sent, bits_packed;
`endif

   int          total = 0, bad = 0;
   logic [31:0] got_q[$];
   logic [31:0] exp_q[$];
   bit          bits_q[$];

   typedef struct packed {
      logic [3:0]        nf;
      logic [8:0][15:0]  d;
      logic [8:0][4:0]   w;
      logic [1:0]        nw;
      logic [1:0][31:0]  exp;
   } vec_t;
   vec_t vecs[7];

   assign done_cpu = auto_ack ? done_auto : done_man;

   rle_word_packer dut (
      .clk(clk), .rst(rst), .field_valid(field_valid), .field_ready(field_ready),
      .field_data(field_data), .field_width(field_width), .flush(flush),
      .load_active(load_active), .data(data), .interrupt(interrupt),
      .load_process(load_process), .done_cpu(done_cpu), .busy(busy), .error(error)
`ifdef RLE_PACK_STATS_EN
      , .words_sent(words_sent), .bits_packed(bits_packed)
`endif
   );

   always #5 clk = ~clk;

   // Automatic loader: capture each word and answer with a one-cycle done_cpu pulse
   initial begin
      forever begin
         @(negedge clk);
         if (auto_ack && interrupt && !done_auto) begin
            got_q.push_back(data);
            done_auto = 1'b1;
         end else begin
            done_auto = 1'b0;
         end
      end
   end

   initial begin
      #5ms;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; field_valid = 1'b0; flush = 1'b0; done_man = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      got_q.delete();
   endtask

   task automatic send_field(input logic [15:0] d, input logic [4:0] w, input logic with_flush);
      int n = 0;
      while (!field_ready && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (!field_ready) begin
         total++; bad++;
         $display("FAIL field_ready_timeout: got 0 expected 1");
      end
      field_valid = 1'b1; field_data = d; field_width = w; flush = with_flush;
      @(negedge clk);
      field_valid = 1'b0; flush = 1'b0;
   endtask

   task automatic pulse_flush();
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while ((busy || interrupt) && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (busy || interrupt) begin
         total++; bad++;
         $display("FAIL idle_timeout: busy=%b interrupt=%b expected 0", busy, interrupt);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic wait_irq(input int budget);
      int n = 0;
      while (!interrupt && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (!interrupt) begin
         total++; bad++;
         $display("FAIL irq_timeout: got 0 expected 1");
      end
   endtask

   task automatic compare_words(input string tag);
      check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check({tag, "_word"}, got_q[i], exp_q[i]);
   endtask

   // Reference: split the stream into maximal runs capped at MAX_RUN, pack eight per word
   task automatic build_expected();
      logic [3:0]  nibs[$];
      logic [31:0] w;
      int          i = 0, n;
      bit          b;
      exp_q.delete();
      while (i < bits_q.size()) begin
         b = bits_q[i];
         n = 0;
         while (i < bits_q.size() && bits_q[i] == b && n < MAX_RUN) begin
            n++; i++;
         end
         nibs.push_back({b, 3'(n)});
      end
      for (int k = 0; k < nibs.size(); k += 8) begin
         w = 32'h0;
         for (int j = 0; j < 8 && k + j < nibs.size(); j++)
            w[31 - 4*j -: 4] = nibs[k + j];
         exp_q.push_back(w);
      end
   endtask

   initial begin
      logic [15:0] d;
      logic [4:0]  w;
      int          k;
      logic        saw_irq, last_flush;

      vecs[0] = '0; vecs[0].nf = 4'd1; vecs[0].d[0] = 16'h0005; vecs[0].w[0] = 5'd6;
      vecs[0].nw = 2'd1; vecs[0].exp[0] = 32'h3919_0000;
      vecs[1] = '0; vecs[1].nf = 4'd1; vecs[1].d[0] = 16'h0000; vecs[1].w[0] = 5'd16;
      vecs[1].nw = 2'd1; vecs[1].exp[0] = 32'h7720_0000;
      vecs[2] = '0; vecs[2].nf = 4'd8; vecs[2].nw = 2'd1; vecs[2].exp[0] = 32'h9191_9191;
      vecs[3] = '0; vecs[3].nf = 4'd9; vecs[3].nw = 2'd2;
      vecs[3].exp[0] = 32'h9191_9191; vecs[3].exp[1] = 32'h9000_0000;
      for (int i = 0; i < 9; i++) begin
         vecs[2].d[i] = (i % 2 == 0) ? 16'h0001 : 16'h0000; vecs[2].w[i] = 5'd1;
         vecs[3].d[i] = (i % 2 == 0) ? 16'h0001 : 16'h0000; vecs[3].w[i] = 5'd1;
      end
      vecs[4] = '0; vecs[4].nf = 4'd2; vecs[4].d[0] = 16'hFFFF; vecs[4].w[0] = 5'd16;
      vecs[4].d[1] = 16'h0001; vecs[4].w[1] = 5'd1; vecs[4].nw = 2'd1; vecs[4].exp[0] = 32'hFFB0_0000;
      vecs[5] = '0; vecs[5].nf = 4'd1; vecs[5].d[0] = 16'hAAAA; vecs[5].w[0] = 5'd16;
      vecs[5].nw = 2'd2; vecs[5].exp[0] = 32'h9191_9191; vecs[5].exp[1] = 32'h9191_9191;
      vecs[6] = '0; vecs[6].nf = 4'd2; vecs[6].d[0] = 16'h1234; vecs[6].w[0] = 5'd0;
      vecs[6].d[1] = 16'h0001; vecs[6].w[1] = 5'd1; vecs[6].nw = 2'd1; vecs[6].exp[0] = 32'h9000_0000;

      // Reset values, with load_active high so load_process must be held clear
      load_active = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_field_ready", 32'(field_ready), 32'd0);
      check("rst_data", data, 32'h0);
      check("rst_interrupt", 32'(interrupt), 32'd0);
      check("rst_load_process", 32'(load_process), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_error", 32'(error), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("load_process_follow", 32'(load_process), 32'd1);
      check("ready_after_rst", 32'(field_ready), 32'd1);
      load_active = 1'b0;
      @(negedge clk);
      check("load_process_drop", 32'(load_process), 32'd0);

      // Table vectors
      for (int v = 0; v < 7; v++) begin
         do_reset();
         for (int f = 0; f < int'(vecs[v].nf); f++)
            send_field(vecs[v].d[f], vecs[v].w[f], 1'b0);
         pulse_flush();
         wait_idle(400);
         check("vec_count", 32'(got_q.size()), 32'(vecs[v].nw));
         for (int i = 0; i < int'(vecs[v].nw) && i < got_q.size(); i++)
            check("vec_word", got_q[i], vecs[v].exp[i]);
         check("vec_busy", 32'(busy), 32'd0);
      end

      // Held acknowledge: word and interrupt must hold while done_cpu stays low
      do_reset();
      auto_ack = 1'b0;
      send_field(16'h0005, 5'd6, 1'b0);
      pulse_flush();
      wait_irq(100);
      for (int c = 0; c < 10; c++) begin
         check("held_irq", 32'(interrupt), 32'd1);
         check("held_data", data, 32'h3919_0000);
         check("held_ready", 32'(field_ready), 32'd0);
         @(negedge clk);
      end
      done_man = 1'b1;
      @(negedge clk);
      check("ack_irq_low", 32'(interrupt), 32'd0);
      done_man = 1'b0;
      repeat (2) @(negedge clk);
      check("ack_busy", 32'(busy), 32'd0);

      // done_cpu already high at entry: needs a fall and a fresh rise
      done_man = 1'b1;
      send_field(16'h0001, 5'd1, 1'b0);
      pulse_flush();
      wait_irq(100);
      check("hi_data", data, 32'h9000_0000);
      repeat (5) begin
         @(negedge clk);
         check("hi_irq_hold", 32'(interrupt), 32'd1);
      end
      done_man = 1'b0;
      repeat (2) begin
         @(negedge clk);
         check("lo_irq_hold", 32'(interrupt), 32'd1);
      end
      done_man = 1'b1;
      @(negedge clk);
      check("rise_irq_low", 32'(interrupt), 32'd0);
      done_man = 1'b0;
      auto_ack = 1'b1;

      // Bad widths: zero drops silently, oversize pulses error once
      do_reset();
      send_field(16'h1234, 5'd0, 1'b0);
      check("w0_error", 32'(error), 32'd0);
      repeat (3) begin
         @(negedge clk);
         check("w0_busy", 32'(busy), 32'd0);
      end
      send_field(16'hFFFF, 5'd17, 1'b0);
      check("w17_error_hi", 32'(error), 32'd1);
      @(negedge clk);
      check("w17_error_lo", 32'(error), 32'd0);
      pulse_flush();
      saw_irq = 1'b0;
      repeat (6) begin
         saw_irq = saw_irq | interrupt;
         @(negedge clk);
      end
      check("w17_no_word", 32'(saw_irq), 32'd0);
      check("w17_busy", 32'(busy), 32'd0);

      // Field and flush in the same cycle: bits first, then flush
      do_reset();
      send_field(16'h0003, 5'd2, 1'b1);
      wait_idle(100);
      exp_q.delete(); exp_q.push_back(32'hA000_0000);
      compare_words("simul");

      // Reset in the middle of a handshake discards everything
      do_reset();
      auto_ack = 1'b0;
      send_field(16'h0005, 5'd6, 1'b0);
      pulse_flush();
      wait_irq(100);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_irq", 32'(interrupt), 32'd0);
      check("mid_rst_data", data, 32'h0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      auto_ack = 1'b1;
      got_q.delete();
      send_field(16'h0001, 5'd1, 1'b0);
      pulse_flush();
      wait_idle(100);
      exp_q.delete(); exp_q.push_back(32'h9000_0000);
      compare_words("post_rst");

      // Randomized segments of fields closed by a flush
      for (int s = 0; s < 40; s++) begin
         got_q.delete();
         bits_q.delete();
         k = $urandom_range(1, 5);
         last_flush = 1'b0;
         for (int f = 0; f < k; f++) begin
            w = ($urandom_range(0, 9) == 0) ? 5'd17 : 5'($urandom_range(0, 16));
            d = 16'($urandom);
            if (w >= 5'd1 && w <= 5'd16)
               for (int i = int'(w) - 1; i >= 0; i--) bits_q.push_back(d[i]);
            last_flush = (f == k - 1) && ($urandom_range(0, 1) == 1);
            send_field(d, w, last_flush);
         end
         if (!last_flush) pulse_flush();
         wait_idle(600);
         build_expected();
         compare_words("rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
